// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results in per-requester FIFOs and broadcasts one per cycle.
// Define CDB_FIXED_PRIO_EN to make the LSB always win contention; otherwise arbitration is round-robin.
`ifndef ROB_ADD_W
`define ROB_ADD_W 5
`endif
`ifndef REG_DAT_W
`define REG_DAT_W 32
`endif

module cdb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  iMp,
  input  logic                  iALU_En,
  input  logic [`ROB_ADD_W-1:0] iALU_Qd,
  input  logic [`REG_DAT_W-1:0] iALU_Vd,
  input  logic [`REG_DAT_W-1:0] iALU_Jt,
  input  logic                  iLSB_En,
  input  logic [`ROB_ADD_W-1:0] iLSB_Qd,
  input  logic [`REG_DAT_W-1:0] iLSB_Vd,
  output logic                  oALU_Rdy,
  output logic                  oLSB_Rdy,
  output logic                  oCDB_En,
  output logic [`ROB_ADD_W-1:0] oCDB_Qd,
  output logic [`REG_DAT_W-1:0] oCDB_Vd,
  output logic [`REG_DAT_W-1:0] oCDB_Jt,
  output logic                  oCDB_Src
);

  localparam int QW = `ROB_ADD_W;
  localparam int DW = `REG_DAT_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [QW-1:0] qd;
    logic [DW-1:0] vd;
    logic [DW-1:0] jt;
  } entry_t;

  // Index 0 is the ALU, index 1 is the LSB throughout.
  entry_t        fifo_q  [2][DEPTH];
  logic [AW-1:0] head_q  [2];
  logic [AW-1:0] tail_q  [2];
  logic [CW-1:0] count_q [2];
  entry_t        cdb_q;
  logic          cdbEn_q;
  logic          cdbSrc_q;
`ifndef CDB_FIXED_PRIO_EN
  logic          lastLsb_q;
`endif

  entry_t     inEntry [2];
  entry_t     cand    [2];
  logic [1:0] inEn;
  logic [1:0] rdy;
  logic [1:0] inValid;
  logic [1:0] candValid;
  logic [1:0] grant;
  logic [1:0] push;
  logic [1:0] pop;
  logic       grantLsb;
  logic       anyGrant;

  always_comb begin
    inEntry[0] = {iALU_Qd, iALU_Vd, iALU_Jt};
    inEntry[1] = {iLSB_Qd, iLSB_Vd, {DW{1'b0}}};
    inEn       = {iLSB_En, iALU_En};
    for (int r = 0; r < 2; r++) begin
      rdy[r]       = en && !iMp && (count_q[r] < CW'(DEPTH));
      // Tag 0 means "no dependency" to the ROB, so it is never worth broadcasting.
      inValid[r]   = inEn[r] && rdy[r] && (inEntry[r].qd != '0);
      candValid[r] = (count_q[r] != '0) || inValid[r];
      cand[r]      = (count_q[r] != '0) ? fifo_q[r][head_q[r]] : inEntry[r];
    end
`ifdef CDB_FIXED_PRIO_EN
    grantLsb = candValid[1];
`else
    grantLsb = candValid[1] && (!candValid[0] || !lastLsb_q);
`endif
    anyGrant = candValid[0] || candValid[1];
    grant[0] = candValid[0] && !grantLsb;
    grant[1] = grantLsb;
    for (int r = 0; r < 2; r++) begin
      push[r] = inValid[r] && !(grant[r] && (count_q[r] == '0));
      pop[r]  = grant[r] && (count_q[r] != '0);
    end
  end

  assign oALU_Rdy = rdy[0];
  assign oLSB_Rdy = rdy[1];
  assign oCDB_En  = cdbEn_q;
  assign oCDB_Qd  = cdb_q.qd;
  assign oCDB_Vd  = cdb_q.vd;
  assign oCDB_Jt  = cdb_q.jt;
  assign oCDB_Src = cdbSrc_q;

  // Storage is left unreset; only the pointers and counts decide what is valid.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) fifo_q[r][tail_q[r]] <= inEntry[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        head_q[r]  <= '0;
        tail_q[r]  <= '0;
        count_q[r] <= '0;
      end
      cdbEn_q   <= 1'b0;
      cdb_q     <= '0;
      cdbSrc_q  <= 1'b0;
`ifndef CDB_FIXED_PRIO_EN
      lastLsb_q <= 1'b1;
`endif
    end else if (en) begin
      if (iMp) begin
        for (int r = 0; r < 2; r++) begin
          head_q[r]  <= '0;
          tail_q[r]  <= '0;
          count_q[r] <= '0;
        end
        cdbEn_q   <= 1'b0;
`ifndef CDB_FIXED_PRIO_EN
        lastLsb_q <= 1'b1;
`endif
      end else begin
        for (int r = 0; r < 2; r++) begin
          head_q[r]  <= head_q[r] + AW'(pop[r]);
          tail_q[r]  <= tail_q[r] + AW'(push[r]);
          count_q[r] <= count_q[r] + CW'(push[r]) - CW'(pop[r]);
        end
        cdbEn_q <= anyGrant;
        if (anyGrant) begin
          cdb_q     <= grantLsb ? cand[1] : cand[0];
          cdbSrc_q  <= grantLsb;
`ifndef CDB_FIXED_PRIO_EN
          lastLsb_q <= grantLsb;
`endif
        end
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, is the per-requester holding buffer depth (power of two, at least 2).
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port en, input, 1 bit: global run enable; low freezes all state.
REQ-005 Port iMp, input, 1 bit: misprediction flush from the ROB.
REQ-006 Ports iALU_En/iALU_Qd/iALU_Vd/iALU_Jt, inputs, 1/`ROB_ADD_W/`REG_DAT_W/`REG_DAT_W bits: ALU result (ROB tag, value, jump target).
REQ-007 Ports iLSB_En/iLSB_Qd/iLSB_Vd, inputs, 1/`ROB_ADD_W/`REG_DAT_W bits: load result; its Jt is treated as 0.
REQ-008 Ports oALU_Rdy and oLSB_Rdy, outputs, 1 bit each: the requester may assert En this cycle.
REQ-009 Ports oCDB_En/oCDB_Qd/oCDB_Vd/oCDB_Jt, outputs, 1/`ROB_ADD_W/`REG_DAT_W/`REG_DAT_W bits, registered: the single broadcast bus to the ROB, RS and LSB.
REQ-010 Port oCDB_Src, output, 1 bit, registered: 0 means the ALU was granted, 1 means the LSB was granted.

Function
REQ-011 Each requester SHALL own a circular FIFO of DEPTH entries {Qd, Vd, Jt}, with a head index, a tail index and a count; indices wrap modulo DEPTH.
REQ-012 The per-cycle candidate for a requester SHALL be its FIFO head when count>0, otherwise its incoming entry when En=1.
REQ-013 At most one candidate is granted per cycle; the granted entry appears on oCDB_* at the next edge with oCDB_En=1, which is 1-cycle latency when uncontended and the FIFO is empty.
REQ-014 An incoming entry that is not granted that cycle SHALL be pushed at the FIFO tail; a granted FIFO head SHALL be popped.
REQ-015 A simultaneous push and pop on the same FIFO SHALL leave count unchanged.
REQ-016 A cycle with no candidate SHALL drive oCDB_En=0 at the next edge; oCDB_Qd/Vd/Jt/Src hold their last values.
REQ-017 Contention (both candidates valid) SHALL be resolved round-robin: the requester not granted most recently wins; the last-grant pointer updates on every grant.
REQ-018 oX_Rdy = en && !iMp && (count_X < DEPTH), combinational from registered count; the requester SHALL NOT assert En when Rdy=0.
REQ-019 An En asserted while Rdy=0 SHALL be ignored: no push, no grant.
REQ-020 An incoming entry with Qd==0 SHALL be discarded; tag 0 is the ROB's "no dependency" value.
REQ-021 With en=0, FIFOs, pointer and all outputs SHALL hold, and inputs SHALL be ignored.
REQ-022 iMp=1 at an edge while en=1 SHALL clear both FIFOs (count, head, tail = 0), set oCDB_En=0, reset the pointer to its reset value, and discard that cycle's inputs; iMp overrides grants.
REQ-023 Per-FIFO order is FIFO; the block gives no ordering guarantee across requesters.

Reset
REQ-024 rst=1 SHALL immediately and asynchronously set all FIFO counts/heads/tails to 0, oCDB_En=0, oCDB_Qd=0, oCDB_Vd=0, oCDB_Jt=0, oCDB_Src=0, last-grant pointer=LSB (so the ALU wins the first contention).
REQ-025 Reset asserted mid-operation SHALL drop all buffered entries; no broadcast occurs on the edge after release unless a candidate is present at that edge.

Configuration
REQ-026 With CDB_FIXED_PRIO_EN defined, contention SHALL always grant the LSB, and the last-grant pointer SHALL be absent.
REQ-027 With CDB_FIXED_PRIO_EN undefined, arbitration SHALL be round-robin per REQ-017; all other behaviour is identical.

Verification
REQ-028 Reset, then a single ALU En with Qd=3, Vd=0x11, Jt=0x40 -> next cycle oCDB_En=1, Qd=3, Vd=0x11, Jt=0x40, Src=0; the cycle after, oCDB_En=0.
REQ-029 ALU (Qd=1) and LSB (Qd=2) both En in the same cycle, round-robin build -> Qd=1 (Src=0), then Qd=2 (Src=1) on consecutive cycles; the fixed-priority build gives the reverse order.
REQ-030 LSB En every cycle with Qd=1,2,3,... while the ALU also sends continuously -> oLSB_Rdy drops when count=DEPTH; no entry is lost or duplicated, and the LSB tag order is preserved.
REQ-031 Two entries buffered, then iMp=1 -> next cycle oCDB_En=0, both Rdy=1, and no stale tag is broadcast afterwards.
REQ-032 en=0 for 3 cycles with one entry buffered -> outputs frozen and Rdy=0; after en=1 the buffered entry is broadcast exactly once.
REQ-033 ALU En with Qd=0 -> no broadcast and count unchanged.
